rsa_job_scheduler: RTL
======================

// Module: rsa_job_scheduler
// PURPOSE
//  Shares one RSA `control` core (inverter + mod_exp) between two requesters.
//  Accepts jobs {p, q, encrypt_decrypt, msg} over per-requester valid/ready.
//  Arbitrates round-robin and sequences the core's reset_inverter/reset_mod_exp
//  pulses and finish waits. Returns msg_out tagged with requester id and a timeout flag.
// PARAMETERS
//  WIDTH    128      prime width; msg/result width is 2*WIDTH
//  TIMEOUT  1000000  max cycles in any WAIT state before abort (>=4)
// PORTS
//  clk                   in   1          system clock, rising edge
//  rst_n                 in   1          asynchronous active-low reset
//  req_valid             in   2          job offered, bit i = requester i
//  req_ready             out  2          job accepted this cycle (one-hot or 0)
//  req_p                 in   2*WIDTH    {p1,p0}
//  req_q                 in   2*WIDTH    {q1,q0}
//  req_ed                in   2          encrypt_decrypt per requester
//  req_msg               in   4*WIDTH    {msg1,msg0}, each 2*WIDTH
//  rsp_valid             out  1          result available
//  rsp_ready             in   1          consumer takes result
//  rsp_id                out  1          requester that owns result
//  rsp_msg               out  2*WIDTH    core msg_out captured at finish
//  rsp_timeout           out  1          job aborted by watchdog, rsp_msg=0
//  core_p, core_q        out  WIDTH      operands to core, held for whole job
//  core_ed               out  1          encrypt_decrypt to core
//  core_msg_in           out  2*WIDTH    message to core
//  core_reset_inverter   out  1          1-cycle start pulse for inverter
//  core_reset_mod_exp    out  1          1-cycle start pulse for mod_exp
//  core_inverter_finish  in   1          inverter done (level)
//  core_mod_exp_finish   in   1          mod_exp done (level)
//  core_msg_out          in   2*WIDTH    core result
// BEHAVIOUR
//  Reset: state=IDLE, every output 0, rr pointer favours requester 0.
//  FSM: IDLE->INV_RST->INV_WAIT->EXP_RST->EXP_WAIT->RESP->IDLE.
//  IDLE: req_ready combinational = grant & req_valid. On handshake, register
//   operands into core_* regs and id, then ->INV_RST. Never accept outside IDLE.
//  Arbitration: only one requester valid -> grant it. Both valid -> grant the
//   one not granted last; pointer updates on handshake only.
//  INV_RST/EXP_RST: assert matching core reset for exactly 1 cycle; clear
//   watchdog; -> *_WAIT.
//  *_WAIT: first cycle ignores finish (stale level from previous job).
//   From cycle 2, finish=1 -> advance. INV->EXP_RST; EXP captures
//   core_msg_out into rsp_msg -> RESP.
//  Watchdog: counter in *_WAIT; reaching TIMEOUT -> RESP, rsp_timeout=1, rsp_msg=0.
//  RESP: rsp_valid=1, data stable until rsp_ready; on handshake -> IDLE and
//   clear rsp_valid/rsp_timeout next cycle. Earliest new accept is the cycle after.
//  Latency (no stalls): accept->core_reset_inverter = 1 cycle;
//   mod_exp_finish sample->rsp_valid = 1 cycle.
//  rst_n low mid-job: immediate IDLE, pulses drop, pending result discarded.
// CONFIGURATION
//  KEY_CACHE_EN defined: keep last {p,q} and a key_valid bit (cleared by reset
//   and by timeout). Accepted job with identical p,q and key_valid=1 skips
//   INV_RST/INV_WAIT: IDLE->EXP_RST directly.
//  Undefined: every job runs the inverter phase; no key storage.
// STRUCTURE
//  Package rsa_sched_pkg: state_e enum, WIDTH default, TIMEOUT default,
//   req_id_t (1 bit), job_t struct {p,q,ed,msg}.
//  Sub-module rsa_rr_arbiter: 2-way round-robin, grant + pointer update on accept.
//  Top holds FSM, operand/result regs, watchdog, optional key cache.
// TESTING
//  T1 req0 p=113680897410347 q=7999808077935876437321 ed=0
//   msg=f03a<<64 -> one inverter pulse, one mod_exp pulse.
//   Then rsp_id=0, rsp_msg=core output.
//  T2 req0/req1 valid same cycle, twice in a row -> grants 0,1,0,1.
//   Single requester repeatedly -> always granted.
//  T3 rsp_ready held low 20 cycles -> rsp_valid/rsp_msg stable.
//   req_ready=0 throughout; accept resumes only after handshake.
//  T4 stub core never raises mod_exp_finish, TIMEOUT=16 ->
//   rsp_timeout=1, rsp_msg=0 after 16 WAIT cycles; next job runs normally.
//  T5 rst_n low during EXP_WAIT -> all outputs 0 asynchronously.
//   After release, new job completes normally.
//  T6 KEY_CACHE_EN: same p,q twice -> second job no core_reset_inverter.
//   Swapped p/q -> inverter runs; undefined build -> inverter every job.

Source files
------------

// File: rtl/rsa_sched_pkg.sv
// Shared types for the RSA job scheduler.
// State encoding, default sizes and the job bundle.
package rsa_sched_pkg;

  localparam int WIDTH_DEF   = 128;
  localparam int TIMEOUT_DEF = 1000000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INV_RST,
    S_INV_WAIT,
    S_EXP_RST,
    S_EXP_WAIT,
    S_RESP
  } state_e;

  typedef logic req_id_t;

  typedef struct packed {
    logic [WIDTH_DEF-1:0]   p;
    logic [WIDTH_DEF-1:0]   q;
    logic                   ed;
    logic [2*WIDTH_DEF-1:0] msg;
  } job_t;

endpackage

// File: rtl/rsa_rr_arbiter.sv
// Two-way round-robin arbiter for the job scheduler.
// Pointer moves only when a grant is taken.
module rsa_rr_arbiter
  import rsa_sched_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] grant
);

  req_id_t last;

  // lone requester wins; on contention favour the one not served last
  always_comb begin
    grant = 2'b00;
    if (en) begin
      unique case (1'b1)
        (&req):  grant = last ? 2'b01 : 2'b10;
        default: grant = req;
      endcase
    end
  end

  // remember who was granted; reset value makes requester 0 win first
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last <= 1'b1;
    end else if (|grant) begin
      last <= grant[1];
    end
  end

endmodule

// File: rtl/rsa_job_scheduler.sv
// Shares one RSA control core between two requesters.
// Optional KEY_CACHE_EN skips the inverter for a repeated {p,q}.
module rsa_job_scheduler
  import rsa_sched_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [1:0]           req_valid,
  output logic [1:0]           req_ready,
  input  logic [2*WIDTH-1:0]   req_p,
  input  logic [2*WIDTH-1:0]   req_q,
  input  logic [1:0]           req_ed,
  input  logic [4*WIDTH-1:0]   req_msg,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic                 rsp_id,
  output logic [2*WIDTH-1:0]   rsp_msg,
  output logic                 rsp_timeout,
  output logic [WIDTH-1:0]     core_p,
  output logic [WIDTH-1:0]     core_q,
  output logic                 core_ed,
  output logic [2*WIDTH-1:0]   core_msg_in,
  output logic                 core_reset_inverter,
  output logic                 core_reset_mod_exp,
  input  logic                 core_inverter_finish,
  input  logic                 core_mod_exp_finish,
  input  logic [2*WIDTH-1:0]   core_msg_out
);

  localparam int MW = 2 * WIDTH;
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] WD_LAST = CW'(TIMEOUT - 1);

  state_e state, state_nx;
  logic [1:0] grant;
  logic arb_en, hs, key_hit, in_wait;
  logic wd_first, wd_done, cap, abort, inv_done;
  req_id_t sel;
  logic [WIDTH-1:0] p_sel, q_sel;
  logic ed_sel;
  logic [MW-1:0] msg_sel;
  logic [CW-1:0] wd;

  assign arb_en = rst_n && (state == S_IDLE);

  rsa_rr_arbiter u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (arb_en),
    .req   (req_valid),
    .grant (grant)
  );

  assign req_ready = grant & req_valid;
  assign hs        = |req_ready;
  assign sel       = req_ready[1];
  assign p_sel     = sel ? req_p[2*WIDTH-1:WIDTH] : req_p[WIDTH-1:0];
  assign q_sel     = sel ? req_q[2*WIDTH-1:WIDTH] : req_q[WIDTH-1:0];
  assign ed_sel    = req_ed[sel];
  assign msg_sel   = sel ? req_msg[2*MW-1:MW] : req_msg[MW-1:0];
  assign in_wait   = (state == S_INV_WAIT) || (state == S_EXP_WAIT);
  assign wd_first  = (wd == '0);
  assign wd_done   = (wd == WD_LAST);
  assign rsp_valid = (state == S_RESP);

`ifdef KEY_CACHE_EN
  logic key_valid;
  logic [WIDTH-1:0] key_p, key_q;

  assign key_hit = key_valid && (p_sel == key_p) && (q_sel == key_q);

  // key becomes usable once the inverter has run for it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_valid <= 1'b0;
      key_p     <= '0;
      key_q     <= '0;
    end else begin
      if (hs) begin
        key_p <= p_sel;
        key_q <= q_sel;
        if (!key_hit) key_valid <= 1'b0;
      end
      if (inv_done) key_valid <= 1'b1;
      if (abort)    key_valid <= 1'b0;
    end
  end
`else
  assign key_hit = 1'b0;
`endif

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  // next state, core start pulses; first wait cycle ignores stale finish
  always_comb begin
    state_nx            = state;
    core_reset_inverter = 1'b0;
    core_reset_mod_exp  = 1'b0;
    cap                 = 1'b0;
    abort               = 1'b0;
    inv_done            = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (hs) state_nx = key_hit ? S_EXP_RST : S_INV_RST;
      end
      S_INV_RST: begin
        core_reset_inverter = 1'b1;
        state_nx            = S_INV_WAIT;
      end
      S_INV_WAIT: begin
        if (!wd_first && core_inverter_finish) begin
          inv_done = 1'b1;
          state_nx = S_EXP_RST;
        end else if (wd_done) begin
          abort    = 1'b1;
          state_nx = S_RESP;
        end
      end
      S_EXP_RST: begin
        core_reset_mod_exp = 1'b1;
        state_nx           = S_EXP_WAIT;
      end
      S_EXP_WAIT: begin
        if (!wd_first && core_mod_exp_finish) begin
          cap      = 1'b1;
          state_nx = S_RESP;
        end else if (wd_done) begin
          abort    = 1'b1;
          state_nx = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // operand capture, watchdog and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_p      <= '0;
      core_q      <= '0;
      core_ed     <= 1'b0;
      core_msg_in <= '0;
      rsp_id      <= 1'b0;
      rsp_msg     <= '0;
      rsp_timeout <= 1'b0;
      wd          <= '0;
    end else begin
      if (hs) begin
        core_p      <= p_sel;
        core_q      <= q_sel;
        core_ed     <= ed_sel;
        core_msg_in <= msg_sel;
        rsp_id      <= sel;
      end
      if (state == S_INV_RST || state == S_EXP_RST) begin
        wd <= '0;
      end else if (in_wait) begin
        wd <= wd + 1'b1;
      end
      if (cap) begin
        rsp_msg     <= core_msg_out;
        rsp_timeout <= 1'b0;
      end else if (abort) begin
        rsp_msg     <= '0;
        rsp_timeout <= 1'b1;
      end else if (rsp_valid && rsp_ready) begin
        rsp_timeout <= 1'b0;
      end
    end
  end

endmodule
